pmod_jstk_responder: RTL and testbench



---
 rtl/jstk_pkg.sv | 22 ++
 rtl/spi_edge_sync.sv | 32 +++
 rtl/pmod_jstk_responder.sv | 144 ++++++++++++++
 tb/tb_pmod_jstk_responder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/jstk_pkg.sv
// Shared constants, state encoding and frame packing for the PmodJSTK responder.
package jstk_pkg;

    localparam int FRAME_BITS = 40;
    localparam logic [5:0] LED_CMD_PREFIX = 6'b100000;

    typedef enum logic [1:0] {
        ST_ARM    = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    // Byte order matches what the PmodJSTK returns: X low, X high, Y low, Y high, buttons.
    function automatic logic [FRAME_BITS-1:0] pack_frame(
        input logic [9:0] x,
        input logic [9:0] y,
        input logic [2:0] btn
    );
        return {x[7:0], 6'b0, x[9:8], y[7:0], 6'b0, y[9:8], 5'b0, btn};
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin with registered rise/fall pulses.
module spi_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
            prev  <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
            rise  <= chain[STAGES-1] & ~prev;
            fall  <= ~chain[STAGES-1] & prev;
        end
    end

    assign level = chain[STAGES-1];

endmodule

// File: rtl/pmod_jstk_responder.sv
// SPI mode-0 slave emulating a PmodJSTK joystick: returns X/Y/buttons, decodes the LED command.
// Define JSTK_RESP_FRAME_ERR_EN to get frame_err pulses on frames that are not exactly 40 bits.
module pmod_jstk_responder
    import jstk_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ss,
    input  logic       sclk,
    input  logic       mosi,
    output logic       miso,
    input  logic [9:0] x_pos,
    input  logic [9:0] y_pos,
    input  logic [2:0] buttons,
    output logic [1:0] led_cmd,
    output logic       frame_done,
    output logic       frame_err
);

    logic ss_level, ss_rise, ss_fall;
    logic sclk_unused_level, sclk_rise, sclk_fall;
    logic [SYNC_STAGES:0] mosi_chain;
    logic mosi_s;

    spi_edge_sync #(.STAGES(SYNC_STAGES)) u_ss_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (ss),
        .level (ss_level),
        .rise  (ss_rise),
        .fall  (ss_fall)
    );

    spi_edge_sync #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (sclk),
        .level (sclk_unused_level),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    // One extra stage keeps mosi aligned with the registered sclk edge pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mosi_chain <= '0;
        end else begin
            mosi_chain <= {mosi_chain[SYNC_STAGES-1:0], mosi};
        end
    end

    assign mosi_s = mosi_chain[SYNC_STAGES];

    state_t                state, state_n;
    logic [FRAME_BITS-1:0] tx, tx_n;
    logic [FRAME_BITS-1:0] rx, rx_n;
    logic [5:0]            bit_cnt, bit_cnt_n;
    logic                  miso_n;
    logic [1:0]            led_cmd_n;
    logic                  frame_done_n, frame_err_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_ARM;
            tx         <= '0;
            rx         <= '0;
            bit_cnt    <= '0;
            miso       <= 1'b0;
            led_cmd    <= 2'b00;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            tx         <= tx_n;
            rx         <= rx_n;
            bit_cnt    <= bit_cnt_n;
            miso       <= miso_n;
            led_cmd    <= led_cmd_n;
            frame_done <= frame_done_n;
            frame_err  <= frame_err_n;
        end
    end

    always_comb begin
        state_n      = state;
        tx_n         = tx;
        rx_n         = rx;
        bit_cnt_n    = bit_cnt;
        miso_n       = 1'b0;
        led_cmd_n    = led_cmd;
        frame_done_n = 1'b0;
        frame_err_n  = 1'b0;

        unique case (state)
            ST_ARM: begin
                if (ss_level) begin
                    state_n = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (ss_fall) begin
                    tx_n      = pack_frame(x_pos, y_pos, buttons);
                    bit_cnt_n = '0;
                    miso_n    = tx_n[FRAME_BITS-1];
                    state_n   = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                miso_n = miso;
                // End of frame takes priority over any sclk edge seen in the same cycle.
                if (ss_rise) begin
                    miso_n  = 1'b0;
                    state_n = ST_IDLE;
                    if (bit_cnt == 6'(FRAME_BITS)) begin
                        frame_done_n = 1'b1;
                        if (rx[FRAME_BITS-1 -: 6] == LED_CMD_PREFIX) begin
                            led_cmd_n = rx[FRAME_BITS-7 -: 2];
                        end
                    end else begin
`ifdef JSTK_RESP_FRAME_ERR_EN
                        frame_err_n = 1'b1;
`else
                        frame_err_n = 1'b0;
`endif
                    end
                end else if (sclk_rise) begin
                    rx_n = {rx[FRAME_BITS-2:0], mosi_s};
                    if (bit_cnt != 6'd63) begin
                        bit_cnt_n = bit_cnt + 6'd1;
                    end
                end else if (sclk_fall) begin
                    tx_n   = {tx[FRAME_BITS-2:0], 1'b0};
                    miso_n = tx[FRAME_BITS-2];
                end
            end
            default: begin
                state_n = ST_ARM;
            end
        endcase
    end

endmodule

// File: tb/tb_pmod_jstk_responder.sv
// Directed self-checking bench for pmod_jstk_responder acting as an SPI mode-0 master.
module tb_pmod_jstk_responder;

`ifdef JSTK_RESP_FRAME_ERR_EN
    localparam int ERR_EN = 1;
`else
    localparam int ERR_EN = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       ss;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic [9:0] x_pos;
    logic [9:0] y_pos;
    logic [2:0] buttons;
    logic [1:0] led_cmd;
    logic       frame_done;
    logic       frame_err;

    int checks_total  = 0;
    int checks_passed = 0;
    int done_total    = 0;
    int err_total     = 0;
    int x_change_bit  = -1;
    logic [9:0] x_change_val = '0;

    pmod_jstk_responder #(.SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .ss         (ss),
        .sclk       (sclk),
        .mosi       (mosi),
        .miso       (miso),
        .x_pos      (x_pos),
        .y_pos      (y_pos),
        .buttons    (buttons),
        .led_cmd    (led_cmd),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    // Counting high cycles makes a stretched pulse show up as a count above one.
    always @(posedge clk) begin
        if (frame_done) done_total++;
        if (frame_err)  err_total++;
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Runs one frame of nbits; mosi_bits is left-aligned, miso_bits collects right-aligned.
    task automatic applyStimulus(input int nbits, input logic [63:0] mosi_bits, output logic [63:0] miso_bits);
        miso_bits = '0;
        @(negedge clk);
        ss = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            mosi = mosi_bits[63-i];
            repeat (8) @(negedge clk);
            miso_bits = {miso_bits[62:0], miso};
            sclk = 1'b1;
            repeat (8) @(negedge clk);
            sclk = 1'b0;
            if (i == x_change_bit) x_pos = x_change_val;
        end
        repeat (8) @(negedge clk);
        ss   = 1'b1;
        mosi = 1'b0;
        repeat (16) @(negedge clk);
    endtask

    function automatic logic [7:0] getByte(input logic [63:0] bits, input int nbits, input int k);
        logic [63:0] shifted;
        shifted = bits >> (nbits - 8 * (k + 1));
        return shifted[7:0];
    endfunction

    task automatic checkJoyBytes(input string tag, input logic [63:0] bits, input int nbits,
                                 input logic [39:0] expected);
        logic [39:0] exp_v;
        exp_v = expected;
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("%s_byte%0d", tag, k), {56'b0, getByte(bits, nbits, k)},
                        {56'b0, exp_v[39 - 8*k -: 8]});
        end
    endtask

    logic [63:0] rx_bits;
    int d0, e0;

    initial begin
        rst = 1'b1; ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
        x_pos = 10'h2A5; y_pos = 10'h013; buttons = 3'b101;
        repeat (4) @(negedge clk);
        checkOutput("reset_miso", {63'b0, miso}, 64'd0);
        checkOutput("reset_led", {62'b0, led_cmd}, 64'd0);
        checkOutput("reset_done", {63'b0, frame_done}, 64'd0);
        checkOutput("reset_err", {63'b0, frame_err}, 64'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Full frame with LED command 0x83.
        d0 = done_total; e0 = err_total;
        applyStimulus(40, 64'h8300_0000_0000_0000, rx_bits);
        checkJoyBytes("f1", rx_bits, 40, 40'hA5_02_13_00_05);
        checkOutput("f1_done", 64'(done_total - d0), 64'd1);
        checkOutput("f1_err", 64'(err_total - e0), 64'd0);
        checkOutput("f1_led", {62'b0, led_cmd}, 64'd3);
        checkOutput("idle_miso", {63'b0, miso}, 64'd0);

        // Bad prefix: frame completes but LEDs hold.
        d0 = done_total;
        applyStimulus(40, 64'h4100_0000_0000_0000, rx_bits);
        checkOutput("badpfx_done", 64'(done_total - d0), 64'd1);
        checkOutput("badpfx_led", {62'b0, led_cmd}, 64'd3);

        // Short frame of 17 bits, then a normal frame.
        d0 = done_total; e0 = err_total;
        applyStimulus(17, 64'h8200_0000_0000_0000, rx_bits);
        checkOutput("short_err", 64'(err_total - e0), 64'(ERR_EN));
        checkOutput("short_done", 64'(done_total - d0), 64'd0);
        checkOutput("short_led", {62'b0, led_cmd}, 64'd3);
        d0 = done_total;
        applyStimulus(40, 64'h8100_0000_0000_0000, rx_bits);
        checkOutput("after_short_done", 64'(done_total - d0), 64'd1);
        checkOutput("after_short_led", {62'b0, led_cmd}, 64'd1);
        checkJoyBytes("after_short", rx_bits, 40, 40'hA5_02_13_00_05);

        // X changes mid-frame; snapshot must hold until the next frame.
        x_pos = 10'h000; x_change_bit = 3; x_change_val = 10'h3FF;
        applyStimulus(40, 64'h8000_0000_0000_0000, rx_bits);
        x_change_bit = -1;
        checkJoyBytes("xmid", rx_bits, 40, 40'h00_00_13_00_05);
        checkOutput("xmid_led", {62'b0, led_cmd}, 64'd0);
        applyStimulus(40, 64'h8200_0000_0000_0000, rx_bits);
        checkJoyBytes("xnext", rx_bits, 40, 40'hFF_03_13_00_05);
        checkOutput("xnext_led", {62'b0, led_cmd}, 64'd2);

        // Reset mid-frame with ss held low; responder must stay silent until ss cycles.
        x_pos = 10'h2A5;
        d0 = done_total; e0 = err_total;
        @(negedge clk);
        ss = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            sclk = 1'b1; repeat (8) @(negedge clk);
            sclk = 1'b0; repeat (8) @(negedge clk);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("midrst_miso", {63'b0, miso}, 64'd0);
        checkOutput("midrst_led", {62'b0, led_cmd}, 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mosi = 1'b1;
            sclk = 1'b1; repeat (8) @(negedge clk);
            checkOutput($sformatf("armed_miso%0d", i), {63'b0, miso}, 64'd0);
            sclk = 1'b0; repeat (8) @(negedge clk);
        end
        ss = 1'b1; mosi = 1'b0;
        repeat (16) @(negedge clk);
        checkOutput("armed_done", 64'(done_total - d0), 64'd0);
        checkOutput("armed_err", 64'(err_total - e0), 64'd0);
        checkOutput("armed_led", {62'b0, led_cmd}, 64'd0);
        d0 = done_total;
        applyStimulus(40, 64'h8300_0000_0000_0000, rx_bits);
        checkJoyBytes("postrst", rx_bits, 40, 40'hA5_02_13_00_05);
        checkOutput("postrst_done", 64'(done_total - d0), 64'd1);
        checkOutput("postrst_led", {62'b0, led_cmd}, 64'd3);

        // 48-bit frame: trailing byte reads zero, frame rejected.
        d0 = done_total; e0 = err_total;
        applyStimulus(48, 64'h8100_0000_0000_0000, rx_bits);
        checkJoyBytes("long", rx_bits, 48, 40'hA5_02_13_00_05);
        checkOutput("long_extra_byte", {56'b0, getByte(rx_bits, 48, 5)}, 64'd0);
        checkOutput("long_err", 64'(err_total - e0), 64'(ERR_EN));
        checkOutput("long_done", 64'(done_total - d0), 64'd0);
        checkOutput("long_led", {62'b0, led_cmd}, 64'd3);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
